// File: rtl/video_line_framer_if.sv
// Groups the pixel-FIFO read port and the DMA pull port of the line framer.
// master: framer side (drives fifo_rd_en, cpu_rd_data, cpu_rd_vld).
// slave : environment side (drives fifo_rd_level, fifo_rd_data, cpu_rd_en).
// Ports: fifo_rd_level/fifo_rd_en/fifo_rd_data (FIFO), cpu_rd_en/cpu_rd_data/cpu_rd_vld (DMA).
interface video_line_framer_if #(
   parameter int LVL_W = 10
);
   logic [LVL_W-1:0] fifo_rd_level;
   logic             fifo_rd_en;
   logic [127:0]     fifo_rd_data;
   logic             cpu_rd_en;
   logic [127:0]     cpu_rd_data;
   logic             cpu_rd_vld;

   modport master (
      input  fifo_rd_level, fifo_rd_data, cpu_rd_en,
      output fifo_rd_en, cpu_rd_data, cpu_rd_vld
   );

   modport slave (
      output fifo_rd_level, fifo_rd_data, cpu_rd_en,
      input  fifo_rd_en, cpu_rd_data, cpu_rd_vld
   );
endinterface

// File: rtl/video_line_framer.sv
// Packs FIFO pixel words into line packets (header + WORDS_PER_LINE body words) pulled by a DMA.
// Latency: cpu_rd_vld/cpu_rd_data follow each cpu_rd_en pull by one cycle; fifo_rd_en is combinational.
// Backpressure: none; the DMA paces everything via cpu_rd_en, gaps simply hold the packet position.
// Ports: clk, rst_n (async active-low), vsync_in (frame sync level), bus (FIFO + DMA signals),
//        frame_cnt (frame-start headers, wraps), drop_cnt (fill packets, saturates).
module video_line_framer #(
   parameter int WORDS_PER_LINE = 160,
   parameter int LVL_W          = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 vsync_in,
   video_line_framer_if.master  bus,
   output logic [15:0]          frame_cnt,
   output logic [15:0]          drop_cnt
);

   localparam int               CNT_W     = $clog2(WORDS_PER_LINE + 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WORDS_PER_LINE);
   localparam logic [31:0]      WPL32     = WORDS_PER_LINE;
   localparam logic [127:0]     FILL_WORD = {8{16'hFFFF}};
   localparam logic [15:0]      TAG_SOF   = 16'hA55A;
   localparam logic [15:0]      TAG_LINE  = 16'hC33C;

   typedef enum logic [1:0] {HDR, LINE, FILL} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] word_cnt;
   logic [LVL_W-1:0] level;
   logic             pull, cnt_last, level_ok;
   logic             hdr_pull, line_pull;
   logic             hdr_sof, hdr_line, hdr_bad;
   logic             vsync_q, vsync_rise, sof_pending;
   logic [15:0]      line_idx, frame_nxt, line_nxt;
   logic [127:0]     hdr_word, word_q;
   logic             line_q, vld_q;

   assign pull     = bus.cpu_rd_en;
   assign cnt_last = (word_cnt == CNT_LAST);
   assign level    = bus.fifo_rd_level;
   assign level_ok = ({{(32-LVL_W){1'b0}}, level} >= WPL32);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= HDR;
      else        state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   // The level is only looked at in HDR, so a mid-packet FIFO flush cannot abort LINE.
   always_comb begin
      state_nxt = state;
      if (pull) begin
         case (state)
            HDR:        state_nxt = level_ok ? LINE : FILL;
            LINE, FILL: if (cnt_last) state_nxt = HDR;
            default:    state_nxt = HDR;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      hdr_pull  = 1'b0;
      line_pull = 1'b0;
      case (state)
         HDR:     hdr_pull  = pull;
         LINE:    line_pull = pull;
         default: ;
      endcase
   end

   assign bus.fifo_rd_en = line_pull;

   // ---------------- header composition ----------------
   assign hdr_sof    = hdr_pull &  level_ok &  sof_pending;
   assign hdr_line   = hdr_pull &  level_ok & ~sof_pending;
   assign hdr_bad    = hdr_pull & ~level_ok;
   assign frame_nxt  = sof_pending ? frame_cnt + 16'd1 : frame_cnt;
   assign line_nxt   = sof_pending ? 16'd0 :
                       (line_idx == 16'hFFFF) ? 16'hFFFF : line_idx + 16'd1;
   assign hdr_word   = {(sof_pending ? TAG_SOF : TAG_LINE), frame_nxt, line_nxt, 80'h0};
   assign vsync_rise = vsync_in & ~vsync_q;

   // ---------------- word counter ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt <= '0;
      end else if (pull) begin
         word_cnt <= cnt_last ? '0 : word_cnt + CNT_W'(1);
      end
   end

   // ---------------- frame / line bookkeeping ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q     <= 1'b0;
         sof_pending <= 1'b0;
         line_idx    <= 16'd0;
         frame_cnt   <= 16'd0;
         drop_cnt    <= 16'd0;
      end else begin
         vsync_q <= vsync_in;
         // A new edge landing on the same cycle as an A55A header must not be lost.
         if (vsync_rise)   sof_pending <= 1'b1;
         else if (hdr_sof) sof_pending <= 1'b0;
         if (hdr_sof | hdr_line) begin
            frame_cnt <= frame_nxt;
            line_idx  <= line_nxt;
         end
         if (hdr_bad && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
   end

   // ---------------- output path ----------------
   // line_q selects the FIFO's one-cycle-late read data; everything else comes from word_q.
   // Clearing line_q on reset keeps stale FIFO data off cpu_rd_data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
         line_q <= 1'b0;
         vld_q  <= 1'b0;
      end else begin
         vld_q  <= pull;
         line_q <= line_pull;
         if (pull && !line_pull) word_q <= (hdr_sof | hdr_line) ? hdr_word : FILL_WORD;
      end
   end

   assign bus.cpu_rd_vld  = vld_q;
   assign bus.cpu_rd_data = line_q ? bus.fifo_rd_data : word_q;

endmodule

// File: doc/video_line_framer.md
VIDEO_LINE_FRAMER -- requirements
Module: video_line_framer

Interface
REQ-001 Parameter WORDS_PER_LINE, 160, number of 128-bit payload words per line packet (1..1023).
REQ-002 Parameter LVL_W, 10, width of the FIFO read-side water level.
REQ-003 clk  input  1  single clock (pclk_div2 domain); all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 vsync_in  input  1  frame sync level, already synchronous to clk.
REQ-006 fifo_rd_level  input  LVL_W  pixel FIFO read-side fill level, in 128-bit words.
REQ-007 fifo_rd_en  output  1  pixel FIFO read strobe; data is returned one cycle later.
REQ-008 fifo_rd_data  input  128  pixel FIFO read data.
REQ-009 cpu_rd_en  input  1  DMA pull strobe, one word per asserted cycle.
REQ-010 cpu_rd_data  output  128  packet word to the DMA.
REQ-011 cpu_rd_vld  output  1  cpu_rd_data is valid this cycle.
REQ-012 frame_cnt  output  16  number of frame-start headers emitted (wraps).
REQ-013 drop_cnt  output  16  number of invalid (fill) packets emitted (saturates at 16'hFFFF).

Function
REQ-014 The packet SHALL be WORDS_PER_LINE+1 pulls: pull 0 is the header and pulls 1..WORDS_PER_LINE are the body; a word counter SHALL wrap to 0 after pull WORDS_PER_LINE.
REQ-015 The word counter SHALL advance only on cycles with cpu_rd_en=1 and SHALL hold otherwise; gaps between pulls are allowed.
REQ-016 The FSM SHALL have states HDR, LINE and FILL; HDR evaluates the header on pull 0.
REQ-017 In HDR on a pull with fifo_rd_level >= WORDS_PER_LINE, the FSM SHALL go to LINE and emit a valid header; otherwise it SHALL go to FILL and emit an invalid header.
REQ-018 The valid header SHALL be: [127:112] = 16'hA55A if sof_pending else 16'hC33C; [111:96] = frame_cnt after the update; [95:80] = line_idx; [79:0] = 0.
REQ-019 The invalid header and every FILL body word SHALL be {8{16'hFFFF}}.
REQ-020 fifo_rd_en SHALL be (cpu_rd_en AND state==LINE), combinational, asserted for exactly WORDS_PER_LINE pulls per valid packet.
REQ-021 cpu_rd_vld SHALL be cpu_rd_en delayed one cycle; cpu_rd_data SHALL be fifo_rd_data when the previous pull was a LINE pull, else the registered header or fill word.
REQ-022 Both LINE and FILL SHALL return to HDR on the pull where the counter reaches WORDS_PER_LINE.
REQ-023 sof_pending SHALL be set on a registered rising edge of vsync_in and cleared when an A55A header is emitted; if both happen in the same cycle, set wins.
REQ-024 Emitting an A55A header SHALL increment frame_cnt (mod 2^16) and SHALL make the header line_idx 0.
REQ-025 Each C33C header SHALL carry line_idx+1; line_idx SHALL saturate at 16'hFFFF.
REQ-026 Each invalid header SHALL increment drop_cnt, saturating at 16'hFFFF; fill packets SHALL NOT change line_idx or sof_pending.
REQ-027 fifo_rd_level SHALL be sampled only in HDR; a level drop mid-packet (for example an external FIFO flush) SHALL NOT abort LINE.
REQ-028 A vsync edge mid-packet SHALL NOT alter the current packet; it SHALL take effect at the next valid header.

Reset
REQ-029 rst_n low SHALL asynchronously force: state=HDR, word counter=0, sof_pending=0, line_idx=0, frame_cnt=0, drop_cnt=0, cpu_rd_vld=0, cpu_rd_data=0, fifo_rd_en=0.
REQ-030 Reset asserted mid-packet SHALL discard the packet; the first pull after release SHALL be treated as a header.

Verification
REQ-031 level=200, vsync pulse, 161 consecutive pulls -> header A55A with frame 1 and line 0, then 160 FIFO words in order, fifo_rd_en high for exactly 160 cycles, cpu_rd_vld lagging by 1 cycle.
REQ-032 level=100, 161 pulls -> header and 160 body words all FFFF, fifo_rd_en never high, drop_cnt=1.
REQ-033 Three valid packets after one vsync -> headers A55A/line 0, C33C/line 1, C33C/line 2; frame_cnt=1.
REQ-034 vsync rising at pull 50 of a LINE packet -> packet completes unchanged; next valid header is A55A with frame_cnt incremented.
REQ-035 Pulls with random gaps (cpu_rd_en 50% duty) -> data sequence identical to the gapless case; the counter holds during gaps.
REQ-036 rst_n low at pull 80, release, level=200 -> first pull is a header, counters are 0, and no stale FIFO data appears on cpu_rd_data.
